// File: rtl/vram_pkg.sv
// Shared widths, types and access tags for the video-memory arbiter.
package vram_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_DISP   = 2'd1,
      TAG_CPU_RD = 2'd2,
      TAG_CPU_WR = 2'd3
   } mem_tag_t;

endpackage

// File: rtl/vram_starve_cnt.sv
// Saturating count of cycles an eligible CPU request has been refused.
module vram_starve_cnt #(
   parameter int unsigned MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam logic [7:0] MAX_C = 8'(MAX);

   logic [7:0] cnt_r;

   // Clear wins over increment; the count sticks at MAX_C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else if (clr) begin
         cnt_r <= 8'd0;
      end else if (inc && (cnt_r != MAX_C)) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video memory arbiter: display reads first, CPU forced through
// after STARVE_MAX refusals; also owns the frame-synchronous bank bit.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-2:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_valid,
   output data_t             disp_data,
   input  logic              frame_start,
   input  logic              bank_sel,
   output logic              bank_active,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  addr_t             cpu_addr,
   input  data_t             cpu_wdata,
   output logic              cpu_ack,
   output data_t             cpu_rdata,
   output logic              mem_enable,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output addr_t             mem_address,
   output data_t             mem_input_data,
   input  data_t             mem_output_data
);

   logic     cpu_elig_s;
   logic     disp_grant_s;
   logic     cpu_grant_s;
   logic     starve_inc_s;
   logic     starve_clr_s;
   logic     at_max_s;
   mem_tag_t next_tag_s;
   mem_tag_t tag_r;
   logic     cpu_busy_r;
   addr_t    addr_hold_r;
   data_t    wdata_hold_r;

   vram_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (starve_inc_s),
      .clr    (starve_clr_s),
      .at_max (at_max_s)
   );

   // Grant selection: starved CPU, then display, then CPU, else idle.
   always_comb begin
      cpu_elig_s   = cpu_req & ~cpu_busy_r;
      disp_grant_s = 1'b0;
      cpu_grant_s  = 1'b0;
      if (at_max_s && cpu_elig_s) begin
         cpu_grant_s = 1'b1;
      end else if (disp_req) begin
         disp_grant_s = 1'b1;
      end else if (cpu_elig_s) begin
         cpu_grant_s = 1'b1;
      end else begin
         cpu_grant_s = 1'b0;
      end
      starve_inc_s = cpu_elig_s & ~cpu_grant_s;
      starve_clr_s = cpu_grant_s | ~cpu_req;
   end

   assign disp_gnt = disp_grant_s;

   // Memory drive for the granted access; idle cycles hold address and data.
   always_comb begin
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      mem_address      = addr_hold_r;
      mem_input_data   = wdata_hold_r;
      next_tag_s       = TAG_NONE;
      if (disp_grant_s) begin
         mem_enable      = 1'b1;
         mem_read_enable = 1'b1;
         mem_address     = {bank_active, disp_addr};
         next_tag_s      = TAG_DISP;
      end else if (cpu_grant_s) begin
         mem_enable       = 1'b1;
         mem_write_enable = cpu_we;
         mem_read_enable  = ~cpu_we;
         mem_address      = cpu_addr;
         mem_input_data   = cpu_wdata;
         next_tag_s       = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else begin
         next_tag_s = TAG_NONE;
      end
   end

   // Tag pipeline, returned data, CPU busy flag and bank latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_r        <= TAG_NONE;
         disp_valid   <= 1'b0;
         disp_data    <= '0;
         cpu_ack      <= 1'b0;
         cpu_rdata    <= '0;
         cpu_busy_r   <= 1'b0;
         bank_active  <= 1'b0;
         addr_hold_r  <= '0;
         wdata_hold_r <= '0;
      end else begin
         tag_r        <= next_tag_s;
         addr_hold_r  <= mem_address;
         wdata_hold_r <= mem_input_data;
         disp_valid   <= 1'b0;
         cpu_ack      <= 1'b0;
         case (tag_r)
            TAG_DISP: begin
               disp_valid <= 1'b1;
               disp_data  <= mem_output_data;
            end
            TAG_CPU_RD: begin
               cpu_ack   <= 1'b1;
               cpu_rdata <= mem_output_data;
            end
            TAG_CPU_WR: begin
               cpu_ack <= 1'b1;
            end
            default: begin
               disp_valid <= 1'b0;
            end
         endcase
         // Busy spans issue through the ack cycle so a held cpu_req is not reissued.
         if (cpu_grant_s) begin
            cpu_busy_r <= 1'b1;
         end else if (cpu_ack) begin
            cpu_busy_r <= 1'b0;
         end else begin
            cpu_busy_r <= cpu_busy_r;
         end
         if (frame_start) begin
            bank_active <= bank_sel;
         end else begin
            bank_active <= bank_active;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 32K x 16 synchronous RAM.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        disp_req = 1'b0;
   logic [13:0] disp_addr = 14'd0;
   logic        disp_gnt;
   logic        disp_valid;
   logic [15:0] disp_data;
   logic        frame_start = 1'b0;
   logic        bank_sel = 1'b0;
   logic        bank_active;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [14:0] cpu_addr = 15'd0;
   logic [15:0] cpu_wdata = 16'd0;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        mem_enable;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [14:0] mem_address;
   logic [15:0] mem_input_data;
   logic [15:0] mem_output_data = 16'd0;

   vram_arbiter #(.STARVE_MAX(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .disp_req         (disp_req),
      .disp_addr        (disp_addr),
      .disp_gnt         (disp_gnt),
      .disp_valid       (disp_valid),
      .disp_data        (disp_data),
      .frame_start      (frame_start),
      .bank_sel         (bank_sel),
      .bank_active      (bank_active),
      .cpu_req          (cpu_req),
      .cpu_we           (cpu_we),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_ack          (cpu_ack),
      .cpu_rdata        (cpu_rdata),
      .mem_enable       (mem_enable),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_address      (mem_address),
      .mem_input_data   (mem_input_data),
      .mem_output_data  (mem_output_data)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] data; int due; } disp_exp_t;
   typedef struct { bit rd; logic [15:0] data; } cpu_exp_t;

   logic [15:0] ram     [0:32767];
   logic [15:0] ref_mem [0:32767];
   disp_exp_t   disp_q[$];
   cpu_exp_t    cpu_q[$];
   int          cyc = 0;
   int          cpu_issues = 0;
   int          last_iss = 0;
   logic        bank_model = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [15:0] preload_word(input int a);
      return 16'((a * 37) ^ 16'h5A00);
   endfunction

   initial begin
      for (int i = 0; i < 32768; i++) begin
         ram[i]     = preload_word(i);
         ref_mem[i] = preload_word(i);
      end
   end

   // RAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_enable) begin
         if (mem_write_enable) ram[mem_address] <= mem_input_data;
         if (mem_read_enable) mem_output_data <= ram[mem_address];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) bank_model <= 1'b0;
      else if (frame_start) bank_model <= bank_sel;
   end

   // Monitor: pushes display expectations on grant, pops on valid/ack.
   always @(negedge clk) begin
      if (!rst) begin
         if (disp_gnt) begin
            check_eq("disp_mem_addr", 32'(mem_address), 32'({bank_model, disp_addr}));
            check_eq("disp_mem_strobes", 32'({mem_enable, mem_read_enable, mem_write_enable}), 32'd6);
            disp_q.push_back('{ref_mem[{bank_model, disp_addr}], cyc + 2});
         end else if (mem_enable) begin
            cpu_issues++;
            last_iss = cyc;
            check_eq("cpu_mem_addr", 32'(mem_address), 32'(cpu_addr));
            check_eq("cpu_mem_strobes", 32'({mem_write_enable, mem_read_enable}), 32'({cpu_we, ~cpu_we}));
            if (cpu_we) check_eq("cpu_mem_wdata", 32'(mem_input_data), 32'(cpu_wdata));
         end
         if (disp_valid) begin
            if (disp_q.size() == 0) begin
               check_eq("disp_valid_spurious", 32'(disp_valid), 32'd0);
            end else begin
               disp_exp_t e;
               e = disp_q.pop_front();
               check_eq("disp_data", 32'(disp_data), 32'(e.data));
               check_eq("disp_latency", 32'(cyc), 32'(e.due));
            end
         end
         if (cpu_ack) begin
            if (cpu_q.size() == 0) begin
               check_eq("cpu_ack_spurious", 32'(cpu_ack), 32'd0);
            end else begin
               cpu_exp_t c;
               c = cpu_q.pop_front();
               check_eq("cpu_ack_latency", 32'(cyc), 32'(last_iss + 2));
               if (c.rd) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(c.data));
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
      check_eq({tag, "_disp_data"}, 32'(disp_data), 32'd0);
      check_eq({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
      check_eq({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
      check_eq({tag, "_bank_active"}, 32'(bank_active), 32'd0);
   endtask

   task automatic cpu_access(input bit we, input logic [14:0] a, input logic [15:0] wd,
                             input bit keep, output int ack_cyc);
      int  iss0;
      bit  got;
      iss0 = cpu_issues;
      got = 1'b0;
      ack_cyc = 0;
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_addr = a;
      cpu_wdata = wd;
      cpu_q.push_back('{!we, ref_mem[a]});
      if (we) ref_mem[a] = wd;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk);
         if (cpu_ack) begin
            got = 1'b1;
            ack_cyc = cyc;
         end
      end
      if (!got) check_eq("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
      @(posedge clk) #1;
      if (!keep) cpu_req = 1'b0;
      check_eq("cpu_one_issue", 32'(cpu_issues - iss0), 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && (disp_q.size() != 0 || cpu_q.size() != 0); k++) @(negedge clk);
      check_eq("drain_disp", 32'(disp_q.size()), 32'd0);
      check_eq("drain_cpu", 32'(cpu_q.size()), 32'd0);
      @(posedge clk) #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  a1, a2, pa;
      bit  drop;

      // Reset state, then reset while a CPU write is issuing.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk) #1 rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 16'hBEEF;
      @(negedge clk);
      check_eq("rst_mid_issue", 32'(mem_write_enable), 32'd1);
      #1 rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      @(posedge clk) #1 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("rst_no_ack", 32'(cpu_ack), 32'd0);
      end

      // Select bank 1, then four back-to-back display reads.
      @(posedge clk) #1 bank_sel = 1'b1; frame_start = 1'b1;
      @(posedge clk) #1 frame_start = 1'b0;
      @(negedge clk);
      check_eq("bank_latch1", 32'(bank_active), 32'd1);
      @(posedge clk) #1;
      for (int i = 0; i < 4; i++) begin
         disp_req = 1'b1;
         disp_addr = 14'(i);
         @(negedge clk);
         check_eq("t2_gnt", 32'(disp_gnt), 32'd1);
         check_eq("t2_addr", 32'(mem_address), 32'h4000 + 32'(i));
         @(posedge clk) #1;
      end
      disp_req = 1'b0;
      drain();

      // CPU write then read-back with the display idle.
      cpu_access(1'b1, 15'h0100, 16'h1234, 1'b0, a1);
      cpu_access(1'b0, 15'h0100, 16'h0000, 1'b0, a2);
      drain();

      // Starvation: display continuous, CPU read raised at k = 3.
      pa = 0;
      drop = 1'b0;
      disp_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         disp_addr = 14'(16 + pa);
         if (k == 3) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
            cpu_q.push_back('{1'b1, ref_mem[15'h0100]});
         end
         if (drop) begin
            cpu_req = 1'b0;
            drop = 1'b0;
         end
         @(negedge clk);
         if (k >= 3 && k <= 13) check_eq("starve_gnt", 32'(disp_gnt), (k == 11) ? 32'd0 : 32'd1);
         if (k == 11) check_eq("starve_cpu_issue", 32'(mem_enable), 32'd1);
         if (disp_gnt) pa++;
         if (cpu_ack) drop = 1'b1;
         @(posedge clk) #1;
      end
      disp_req = 1'b0;
      cpu_req = 1'b0;
      drain();

      // Bank switch takes effect only at frame_start.
      disp_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         disp_addr = 14'(k);
         if (k == 2) bank_sel = 1'b0;
         frame_start = (k == 5);
         @(negedge clk);
         check_eq("bank_active", 32'(bank_active), (k <= 5) ? 32'd1 : 32'd0);
         check_eq("bank_msb", 32'(mem_address[14]), (k <= 5) ? 32'd1 : 32'd0);
         @(posedge clk) #1;
      end
      frame_start = 1'b0;
      disp_req = 1'b0;
      drain();

      // Back-to-back CPU requests with cpu_req held through the first ack.
      cpu_access(1'b1, 15'h0200, 16'hA5A5, 1'b1, a1);
      cpu_access(1'b0, 15'h0200, 16'h0000, 1'b0, a2);
      check_eq("b2b_gap", 32'(a2 - a1), 32'd3);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
